// File: rtl/ll_pkg.sv
// Shared types and helpers for the free-pointer pool.
package ll_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ll_state_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic range;
    logic double_free;
  } ll_err_t;

  function automatic logic ptr_in_range(input int unsigned ptr,
                                        input int unsigned base,
                                        input int unsigned num);
    return (ptr >= base) && (ptr < base + num);
  endfunction

endpackage

// File: rtl/ll_ptr_ring.sv
// Circular pointer store with show-ahead head, occupancy count and
// non-power-of-two index wrap.
module ll_ptr_ring
  import ll_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int DEPTH   = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [A_WIDTH-1:0] push_ptr_i,
  input  logic               pop_i,
  output logic [A_WIDTH-1:0] head_o,
  output logic [A_WIDTH:0]   count_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [A_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]      rd_idx, wr_idx;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_idx  <= '0;
      wr_idx  <= '0;
      count_o <= '0;
    end else begin
      if (push_i) wr_idx <= nxt(wr_idx);
      if (pop_i)  rd_idx <= nxt(rd_idx);
      case ({push_i, pop_i})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  // Storage needs no reset; the head is only consumed when count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_idx] <= push_ptr_i;
  end

  assign head_o = mem[rd_idx];

endmodule

// File: rtl/ll_free_ptr_pool.sv
// Free-pointer allocator: self-init FSM, range/overflow/underflow checks, sticky errors.
// Optional macro LL_DOUBLE_FREE_CHK_EN adds an in-pool bitmap for double-free detection.
module ll_free_ptr_pool
  import ll_pkg::*;
#(
  parameter int A_WIDTH  = 8,
  parameter int PTR_NUM  = 2**A_WIDTH,
  parameter int PTR_BASE = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] free_ptr_i,
  input  logic               free_en_i,
  input  logic               alloc_ack_i,
  output logic [A_WIDTH-1:0] alloc_ptr_o,
  output logic               alloc_val_o,
  output logic               init_done_o,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               err_overflow_o,
  output logic               err_underflow_o,
  output logic               err_range_o,
  output logic               err_double_free_o,
  input  logic               err_clr_i
);

  localparam logic [A_WIDTH-1:0] BASE_W = A_WIDTH'(PTR_BASE);
  localparam logic [A_WIDTH-1:0] LAST_I = A_WIDTH'(PTR_NUM - 1);
  localparam logic [A_WIDTH:0]   FULL   = (A_WIDTH+1)'(PTR_NUM);

  ll_state_t          state_q, state_d;
  logic [A_WIDTH-1:0] init_cnt_q, head, push_ptr;
  logic [A_WIDTH:0]   cnt;
  logic               push, pop, in_rng, full, dbl;
  ll_err_t            err_q, err_set;

  ll_ptr_ring #(.A_WIDTH(A_WIDTH), .DEPTH(PTR_NUM)) u_ring (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_ptr_i (push_ptr),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (cnt)
  );

  assign in_rng      = ptr_in_range(32'(free_ptr_i), PTR_BASE, PTR_NUM);
  assign full        = (cnt == FULL);
  assign init_done_o = (state_q == RUN);
  assign alloc_val_o = (state_q == RUN) && (cnt != '0);
  assign alloc_ptr_o = alloc_val_o ? head : '0;
  assign free_cnt_o  = cnt;
  assign pop         = alloc_ack_i && alloc_val_o;

`ifdef LL_DOUBLE_FREE_CHK_EN
  logic [PTR_NUM-1:0] in_pool_q, free_hit, head_hit, push_hit;

  always_comb begin
    free_hit = '0;
    head_hit = '0;
    push_hit = '0;
    for (int k = 0; k < PTR_NUM; k++) begin
      free_hit[k] = (free_ptr_i == BASE_W + A_WIDTH'(k));
      head_hit[k] = (head       == BASE_W + A_WIDTH'(k));
      push_hit[k] = (push_ptr   == BASE_W + A_WIDTH'(k));
    end
  end

  // Returning the pointer being acked in the same cycle is a legal recycle.
  assign dbl = |(in_pool_q & free_hit) && !(pop && (head == free_ptr_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) in_pool_q <= '0;
    else       in_pool_q <= (in_pool_q & ~(pop ? head_hit : '0)) | (push ? push_hit : '0);
  end
`else
  assign dbl = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      err_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt_q <= init_cnt_q + 1'b1;
      err_q <= err_clr_i ? '0 : (err_q | err_set);
    end
  end

  always_comb begin
    state_d           = state_q;
    push              = 1'b0;
    push_ptr          = free_ptr_i;
    err_set           = '0;
    err_set.underflow = alloc_ack_i && !alloc_val_o;
    err_set.range     = free_en_i && !in_rng;
    if (state_q == INIT) begin
      push             = 1'b1;
      push_ptr         = BASE_W + init_cnt_q;
      err_set.overflow = free_en_i;
      if (init_cnt_q == LAST_I) state_d = RUN;
    end else if (free_en_i && in_rng) begin
      // A full pool still accepts a free when a pop vacates a slot this cycle.
      if (dbl)              err_set.double_free = 1'b1;
      else if (full && !pop) err_set.overflow   = 1'b1;
      else                   push               = 1'b1;
    end
  end

  assign err_overflow_o    = err_q.overflow;
  assign err_underflow_o   = err_q.underflow;
  assign err_range_o       = err_q.range;
  assign err_double_free_o = err_q.double_free;

endmodule

// File: tb/tb_ll_free_ptr_pool.sv
// Scoreboard bench for ll_free_ptr_pool against a queue-based pool model.
module tb_ll_free_ptr_pool;

  localparam int AW   = 8;
  localparam int N    = 6;
  localparam int BASE = 10;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [AW-1:0] free_ptr_i = '0;
  logic          free_en_i = 1'b0, alloc_ack_i = 1'b0, err_clr_i = 1'b0;
  logic [AW-1:0] alloc_ptr_o;
  logic          alloc_val_o, init_done_o;
  logic [AW:0]   free_cnt_o;
  logic          err_overflow_o, err_underflow_o, err_range_o, err_double_free_o;

  ll_free_ptr_pool #(.A_WIDTH(AW), .PTR_NUM(N), .PTR_BASE(BASE)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .free_ptr_i        (free_ptr_i),
    .free_en_i         (free_en_i),
    .alloc_ack_i       (alloc_ack_i),
    .alloc_ptr_o       (alloc_ptr_o),
    .alloc_val_o       (alloc_val_o),
    .init_done_o       (init_done_o),
    .free_cnt_o        (free_cnt_o),
    .err_overflow_o    (err_overflow_o),
    .err_underflow_o   (err_underflow_o),
    .err_range_o       (err_range_o),
    .err_double_free_o (err_double_free_o),
    .err_clr_i         (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0;

  // status = {val, init_done, count[8:0], of, uf, rg, df}
  typedef logic [14:0] st_t;
  st_t st_q[$];
  int  ptr_q[$];
  st_t exp_st;
  int  exp_ptr;

  // Reference pool: a plain FIFO of pointer values plus init progress.
  int       mq[$];
  bit       m_run;
  int       m_icnt;
  bit [3:0] m_err;

  function automatic bit m_has(int p);
    foreach (mq[k]) if (mq[k] == p) return 1'b1;
    return 1'b0;
  endfunction

  function st_t dut_st();
    return {alloc_val_o, init_done_o, free_cnt_o,
            err_overflow_o, err_underflow_o, err_range_o, err_double_free_o};
  endfunction

  function st_t model_st();
    bit v;
    v = m_run && (mq.size() != 0);
    return {v, m_run, 9'(mq.size()), m_err};
  endfunction

  task automatic model_step(bit fe, int p, bit ak, bit cl);
    bit v, pop, push, inr;
    bit [3:0] s;
    v    = m_run && (mq.size() != 0);
    pop  = ak && v;
    push = 1'b0;
    s    = '0;
    inr  = (p >= BASE) && (p < BASE + N);
    if (ak && !v) s[2] = 1'b1;
    if (fe && !inr) s[1] = 1'b1;
    if (!m_run) begin
      if (fe) s[3] = 1'b1;
    end else if (fe && inr) begin
`ifdef LL_DOUBLE_FREE_CHK_EN
      if (m_has(p) && !(pop && mq[0] == p)) s[0] = 1'b1;
      else
`endif
      if (mq.size() == N && !pop) s[3] = 1'b1;
      else push = 1'b1;
    end
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(p);
    if (!m_run) begin
      mq.push_back(BASE + m_icnt);
      m_icnt++;
      if (m_icnt == N) m_run = 1'b1;
    end
    m_err = cl ? 4'b0 : (m_err | s);
  endtask

  // Advance one clock: retire the previous inputs into the model, queue the
  // expected status, then drive the new inputs.
  task automatic cyc(bit fe, int p, bit ak, bit cl);
    @(posedge clk_i); #1;
    model_step(free_en_i, int'(free_ptr_i), alloc_ack_i, err_clr_i);
    st_q.push_back(model_st());
    free_en_i   = fe;
    free_ptr_i  = AW'(p);
    alloc_ack_i = ak;
    err_clr_i   = cl;
    if (ak && m_run && mq.size() != 0) ptr_q.push_back(mq[0]);
  endtask

  task automatic check_zero(string name);
    n_cmp++;
    if ({alloc_ptr_o, dut_st()} !== '0) begin
      n_err++;
      $display("FAIL %s: got ptr=%0d status=%b, want all zero", name, alloc_ptr_o, dut_st());
    end
  endtask

  task automatic apply_reset(string name);
    @(negedge clk_i); #2;
    rst_i = 1'b1;
    free_en_i = 1'b0; free_ptr_i = '0; alloc_ack_i = 1'b0; err_clr_i = 1'b0;
    mq.delete(); m_run = 1'b0; m_icnt = 0; m_err = '0;
    #1 check_zero(name);
    @(negedge clk_i); #2;
    rst_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (st_q.size() != 0) begin
        exp_st = st_q.pop_front();
        n_cmp++;
        if (dut_st() !== exp_st) begin
          n_err++;
          $display("FAIL status @%0t: got val=%b init=%b cnt=%0d err=%b, want val=%b init=%b cnt=%0d err=%b",
                   $time, dut_st()[14], dut_st()[13], dut_st()[12:4], dut_st()[3:0],
                   exp_st[14], exp_st[13], exp_st[12:4], exp_st[3:0]);
        end
      end
      if (alloc_ack_i && alloc_val_o) begin
        n_cmp++;
        if (ptr_q.size() == 0) begin
          n_err++;
          $display("FAIL alloc @%0t: got ptr=%0d, want no valid alloc", $time, alloc_ptr_o);
        end else begin
          exp_ptr = ptr_q.pop_front();
          if (int'(alloc_ptr_o) != exp_ptr) begin
            n_err++;
            $display("FAIL alloc_ptr @%0t: got %0d, want %0d", $time, alloc_ptr_o, exp_ptr);
          end
        end
      end
    end
  end

  initial begin
    bit fe, ak, cl;
    int p;
    #1 check_zero("reset_at_start");
    apply_reset("reset_first");

    // Init with a stray free and ack, then clear the flags.
    cyc(0, 0, 0, 0); cyc(1, 11, 0, 0); cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    // Drain in FIFO order, then underflow.
    repeat (6) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
    // Free into empty pool; simultaneous free+ack at count 1.
    cyc(1, 12, 0, 0); cyc(1, 13, 1, 0); cyc(0, 0, 1, 0);
    // Fill, free+ack at full, overflow, range error, clear.
    for (int i = 0; i < N; i++) cyc(1, BASE + i, 0, 0);
    cyc(0, 0, 0, 0); cyc(1, 10, 1, 0); cyc(1, 11, 0, 0);
    cyc(1, 200, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);

    // Reset mid-run at count 2, then full re-init.
    apply_reset("reset_restart");
    repeat (6) cyc(0, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    apply_reset("reset_mid_run");
    repeat (7) cyc(0, 0, 0, 0);
    // Alloc 10 and 11, then return 10 twice.
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    cyc(1, 10, 0, 0); cyc(1, 10, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);

    // Random traffic: free-heavy first half, ack-heavy second half.
    for (int i = 0; i < 600; i++) begin
      fe = 1'($urandom_range(0, 1));
      p  = ($urandom_range(0, 19) == 0) ? 200 : int'($urandom_range(8, 17));
      ak = ($urandom_range(0, 99) < ((i < 300) ? 30 : 65));
      cl = ($urandom_range(0, 31) == 0);
      cyc(fe, p, ak, cl);
    end
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    @(negedge clk_i); #2;

    n_cmp++;
    if (st_q.size() != 0 || ptr_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d status / %0d ptr entries left, want 0 / 0",
               st_q.size(), ptr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
